// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period capture with stuck-line timeout
module pwm_capture #(
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             stuck_lo,
    output logic             stuck_hi,
    output logic             valid
);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HIGH, ST_LOW} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise, fall, at_to;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [CNT_W-1:0] per_nxt, hi_nxt;
    logic [CNT_W-1:0] per_inc, hi_inc;
    logic             load_meas, load_to;

    // s1/s2 resolve metastability on the asynchronous line; s3 is the edge reference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign at_to   = (per_cnt == TO_CNT);
    assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + 1'b1;
    assign hi_inc  = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (rise)       state_nxt = ST_HIGH;
                    else if (at_to) state_nxt = ST_WAIT;
                end
                ST_HIGH: begin
                    if (at_to)      state_nxt = ST_WAIT;
                    else if (fall)  state_nxt = ST_LOW;
                end
                ST_LOW: begin
                    if (rise)       state_nxt = ST_HIGH;
                    else if (at_to) state_nxt = ST_WAIT;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Counter updates and report strobes; a rise always wins over a timeout
    always_comb begin
        per_nxt   = per_cnt;
        hi_nxt    = hi_cnt;
        load_meas = 1'b0;
        load_to   = 1'b0;
        if (!en || state == ST_IDLE) begin
            per_nxt = '0;
            hi_nxt  = '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (rise) begin
                        per_nxt = CNT_W'(1);
                        hi_nxt  = CNT_W'(1);
                    end else if (at_to) begin
                        load_to = 1'b1;
                        per_nxt = CNT_W'(1);
                        hi_nxt  = '0;
                    end else begin
                        per_nxt = per_inc;
                    end
                end
                ST_HIGH: begin
                    if (at_to) begin
                        load_to = 1'b1;
                        per_nxt = CNT_W'(1);
                        hi_nxt  = '0;
                    end else begin
                        per_nxt = per_inc;
                        if (!fall) hi_nxt = hi_inc;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        load_meas = 1'b1;
                        per_nxt   = CNT_W'(1);
                        hi_nxt    = CNT_W'(1);
                    end else if (at_to) begin
                        load_to = 1'b1;
                        per_nxt = CNT_W'(1);
                        hi_nxt  = '0;
                    end else begin
                        per_nxt = per_inc;
                    end
                end
                default: begin
                    per_nxt = '0;
                    hi_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt   <= '0;
            hi_cnt    <= '0;
            high_time <= '0;
            period    <= '0;
            stuck_lo  <= 1'b0;
            stuck_hi  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            per_cnt <= per_nxt;
            hi_cnt  <= hi_nxt;
            valid   <= load_meas | load_to;
            if (load_meas) begin
                high_time <= hi_cnt;
                period    <= per_cnt;
                stuck_lo  <= 1'b0;
                stuck_hi  <= 1'b0;
            end else if (load_to) begin
                high_time <= '0;
                period    <= '0;
                stuck_lo  <= ~s2;
                stuck_hi  <= s2;
            end
        end
    end
endmodule
